// File: rtl/cnn_img_feeder.sv
`default_nettype none
// ============================================================================
// Module  : cnn_img_feeder
// Brief   : Collects IMG_SIZE pixel words into a flat image, runs the CNN core
//           and hands its prediction downstream. Optional watchdog built in
//           when CNN_FEEDER_TIMEOUT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module cnn_img_feeder #(
  parameter int IMG_SIZE       = 64,
  parameter int DATA_W         = 32,
  parameter int OUT_W          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  input  logic [DATA_W-1:0]          s_data,
  output logic                       s_ready,
  output logic                       cnn_enable,
  output logic [IMG_SIZE*DATA_W-1:0] cnn_img,
  input  logic [OUT_W-1:0]           cnn_value,
  input  logic                       cnn_done,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [OUT_W-1:0]           r_value,
  output logic                       r_timeout,
  output logic                       busy
);

  localparam int CNT_W = $clog2(IMG_SIZE) + 1;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_s_ready;
  logic             w_accept;
  logic             w_last;
  logic             w_wd_expire;

  assign w_accept   = s_valid && r_s_ready && (r_state == ST_LOAD);
  assign w_last     = w_accept && (r_cnt == CNT_W'(IMG_SIZE - 1));
  assign s_ready    = r_s_ready;
  assign cnn_enable = (r_state == ST_RUN);
  assign busy       = !((r_state == ST_LOAD) && (r_cnt == '0));

`ifdef CNN_FEEDER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd;
  logic            r_to;

  // Counter is zero on the first RUN cycle, so expiry lands TIMEOUT_CYCLES edges after entry.
  assign w_wd_expire = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign r_timeout   = r_to;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd <= '0;
      r_to <= 1'b0;
    end else begin
      if (r_state != ST_RUN) r_wd <= '0;
      else                   r_wd <= r_wd + WD_W'(1);
      if (r_state == ST_RUN) begin
        if (cnn_done)         r_to <= 1'b0;
        else if (w_wd_expire) r_to <= 1'b1;
      end
    end
  end
`else
  logic w_unused_tmo;

  assign w_wd_expire  = 1'b0;
  assign r_timeout    = 1'b0;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD:   if (w_last) w_state_nxt = ST_RUN;
      ST_RUN:    if (cnn_done || w_wd_expire) w_state_nxt = ST_RESULT;
      ST_RESULT: if (r_ready) w_state_nxt = ST_LOAD;
      default:   w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_ready <= 1'b0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_value   <= '0;
    end else begin
      r_s_ready <= (w_state_nxt == ST_LOAD);
      case (r_state)
        ST_LOAD: begin
          if (w_accept) r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_RUN: begin
          // A completion on the expiry edge wins over the watchdog.
          if (cnn_done) begin
            r_value <= cnn_value;
            r_valid <= 1'b1;
          end else if (w_wd_expire) begin
            r_value <= '0;
            r_valid <= 1'b1;
          end
        end
        ST_RESULT: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Image is only ever overwritten word by word; it is never cleared outside reset.
  for (genvar k = 0; k < IMG_SIZE; k++) begin : g_pix
    logic [DATA_W-1:0] r_pix;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                r_pix <= '0;
      else if (w_accept && (r_cnt == CNT_W'(k))) r_pix <= s_data;
    end

    assign cnn_img[k*DATA_W +: DATA_W] = r_pix;
  end

endmodule
`default_nettype wire

// File: tb/tb_cnn_img_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_cnn_img_feeder
// Brief   : Randomised self-checking bench for cnn_img_feeder against an
//           image/result model held in plain arrays.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cnn_img_feeder;

  localparam int IMG = 64;
  localparam int DW  = 32;
  localparam int OW  = 32;
`ifdef CNN_FEEDER_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif
  localparam int DONE_MAX  = (TMO > 30) ? 30 : TMO - 1;
  localparam int ONES_DONE = (TMO > 20) ? 20 : TMO - 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic [DW-1:0]     s_data = '0;
  logic              s_ready;
  logic              cnn_enable;
  logic [IMG*DW-1:0] cnn_img;
  logic [OW-1:0]     cnn_value = '0;
  logic              cnn_done = 1'b0;
  logic              r_valid;
  logic              r_ready = 1'b0;
  logic [OW-1:0]     r_value;
  logic              r_timeout;
  logic              busy;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_img [IMG];
  logic [OW-1:0] exp_val;

  cnn_img_feeder #(
    .IMG_SIZE(IMG), .DATA_W(DW), .OUT_W(OW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .cnn_enable(cnn_enable), .cnn_img(cnn_img), .cnn_value(cnn_value),
    .cnn_done(cnn_done), .r_valid(r_valid), .r_ready(r_ready), .r_value(r_value),
    .r_timeout(r_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the whole image against the model, reporting the first bad pixel.
  task automatic cmp_img(input string name);
    int bad_k = -1;
    for (int k = 0; k < IMG; k++)
      if (bad_k < 0 && cnn_img[k*DW +: DW] !== exp_img[k]) bad_k = k;
    total++;
    if (bad_k >= 0) begin
      bad++;
      $display("FAIL %s: pixel %0d got %0h want %0h", name, bad_k,
               cnn_img[bad_k*DW +: DW], exp_img[bad_k]);
    end
  endtask

  // mode 0: all ones back-to-back; 1: value k, s_valid toggling; 2: random data and gaps
  task automatic load_image(input int mode, input int n);
    int  k = 0;
    int  cyc = 0;
    bit  acc;
    bit  ph = 1'b1;
    for (int i = 0; i < n; i++)
      exp_img[i] = (mode == 0) ? 32'd1 : (mode == 1) ? DW'(i) : $urandom;
    while (k < n) begin
      case (mode)
        0:       s_valid = 1'b1;
        1:       begin s_valid = ph; ph = ~ph; end
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = exp_img[k];
      acc = s_valid && s_ready;
      tick();
      if (acc) k++;
      cyc++;
      if (cyc > 4 * IMG + 20) begin
        total++; bad++;
        $display("FAIL load_budget: accepted %0d want %0d", k, n);
        break;
      end
    end
    s_valid = (mode == 1) ? 1'b1 : 1'b0;
    s_data  = 32'hDEAD_BEEF;
    if (n == IMG) begin
      cmp_img("load_image");
      total++;
      if ({cnn_enable, s_ready, busy, r_valid} !== 4'b1010) begin
        bad++;
        $display("FAIL run_entry: en/rdy/busy/rv got %b want 1010",
                 {cnn_enable, s_ready, busy, r_valid});
      end
    end
  endtask

  task automatic run_cnn(input int done_at, input logic [OW-1:0] v);
    int en = 0;
    int early = 0;
    int rdy = 0;
    for (int c = 1; c <= done_at; c++) begin
      if (cnn_enable) en++;
      if (r_valid) early++;
      if (s_ready) rdy++;
      cnn_done  = (c == done_at);
      cnn_value = (c == done_at) ? v : $urandom;
      tick();
    end
    cnn_done = 1'b0;
    exp_val  = v;
    total++;
    if (en != done_at || early != 0 || rdy != 0) begin
      bad++;
      $display("FAIL run_window: en_cycles=%0d want %0d, early_rvalid=%0d, s_ready_cycles=%0d",
               en, done_at, early, rdy);
    end
    total++;
    if ({cnn_enable, r_valid, r_timeout} !== 3'b010 || r_value !== v) begin
      bad++;
      $display("FAIL run_result: en/rv/to=%b want 010 value=%0h want %0h",
               {cnn_enable, r_valid, r_timeout}, r_value, v);
    end
    cmp_img("img_stable_run");
  endtask

  task automatic consume();
    s_valid = 1'b0;
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    total++;
    if ({s_ready, r_valid, busy} !== 3'b100) begin
      bad++;
      $display("FAIL consume: rdy/rv/busy got %b want 100", {s_ready, r_valid, busy});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({s_ready, cnn_enable, r_valid, r_timeout, busy} !== 5'b0 ||
        r_value !== '0 || cnn_img !== '0) begin
      bad++;
      $display("FAIL reset_values: flags=%b value=%0h", 
               {s_ready, cnn_enable, r_valid, r_timeout, busy}, r_value);
    end
    rst = 1'b0;
    tick();
    total++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: s_ready=%b busy=%b want 1 0", s_ready, busy);
    end
  endtask

  task automatic test_stream_ones();
    load_image(0, IMG);
    run_cnn(ONES_DONE, 32'd7);
    consume();
  endtask

  task automatic test_toggle_valid();
    load_image(1, IMG);
    run_cnn(int'($urandom_range(1, DONE_MAX)), $urandom);
    consume();
  endtask

  task automatic test_result_hold();
    int errs = 0;
    load_image(2, IMG);
    run_cnn(int'($urandom_range(1, DONE_MAX)), 32'd7);
    for (int c = 0; c < 10; c++) begin
      cnn_done  = 1'($urandom_range(0, 1));
      cnn_value = $urandom;
      tick();
      if ({r_valid, s_ready, cnn_enable} !== 3'b100 || r_value !== exp_val) errs++;
    end
    cnn_done = 1'b0;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL result_hold: %0d unstable cycles, value=%0h want %0h", errs, r_value, exp_val);
    end
    cmp_img("img_stable_result");
    consume();
    load_image(2, IMG);
    run_cnn(int'($urandom_range(1, DONE_MAX)), $urandom);
    consume();
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    load_image(2, 30);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({s_ready, cnn_enable, r_valid, r_timeout, busy} !== 5'b0 ||
        r_value !== '0 || cnn_img !== '0) begin
      bad++;
      $display("FAIL abort_load: flags=%b value=%0h",
               {s_ready, cnn_enable, r_valid, r_timeout, busy}, r_value);
    end
    repeat (2) begin tick(); if (r_valid !== 1'b0) pulses++; end
    rst = 1'b0;
    tick();
    total++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_release: s_ready=%b busy=%b want 1 0", s_ready, busy);
    end
    load_image(2, IMG);
    cnn_done = 1'b0;
    repeat (5) begin tick(); if (r_valid !== 1'b0) pulses++; end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({s_ready, cnn_enable, r_valid, r_timeout, busy} !== 5'b0 ||
        r_value !== '0 || cnn_img !== '0) begin
      bad++;
      $display("FAIL abort_run: flags=%b value=%0h",
               {s_ready, cnn_enable, r_valid, r_timeout, busy}, r_value);
    end
    repeat (2) begin tick(); if (r_valid !== 1'b0) pulses++; end
    rst = 1'b0;
    tick();
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL abort_no_result: r_valid high %0d cycles want 0", pulses);
    end
    load_image(2, IMG);
    run_cnn(int'($urandom_range(1, DONE_MAX)), $urandom);
    consume();
  endtask

`ifdef CNN_FEEDER_TIMEOUT_EN
  task automatic test_watchdog();
    int en = 0;
    int early = 0;
    load_image(2, IMG);
    for (int c = 1; c <= TMO; c++) begin
      if (cnn_enable) en++;
      if (r_valid) early++;
      cnn_value = $urandom;
      tick();
    end
    total++;
    if (en != TMO || early != 0 || {r_valid, r_timeout, cnn_enable} !== 3'b110 ||
        r_value !== '0) begin
      bad++;
      $display("FAIL watchdog: en=%0d early=%0d rv/to/en=%b value=%0h want %0d 0 110 0",
               en, early, {r_valid, r_timeout, cnn_enable}, r_value, TMO);
    end
    consume();
    load_image(2, IMG);
    run_cnn(TMO, $urandom);
    consume();
  endtask
`else
  task automatic test_watchdog();
    int errs = 0;
    load_image(2, IMG);
    for (int c = 0; c < 40; c++) begin
      if ({cnn_enable, r_valid, r_timeout} !== 3'b100) errs++;
      tick();
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL wait_forever: %0d cycles left RUN without cnn_done", errs);
    end
    run_cnn(1, $urandom);
    consume();
  endtask
`endif

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      load_image(2, IMG);
      run_cnn(int'($urandom_range(1, DONE_MAX)), $urandom);
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_stream_ones();
    test_toggle_valid();
    test_result_hold();
    test_reset_abort();
    test_watchdog();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/cnn_img_feeder.md
CNN_IMG_FEEDER -- requirements
Module: cnn_img_feeder

Interface
REQ-001 Parameter IMG_SIZE, default 64, number of 32-bit pixel words per image.
REQ-002 Parameter DATA_W, default 32, pixel word width.
REQ-003 Parameter OUT_W, default 32, prediction width.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024, watchdog limit in cycles.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 s_valid  in  1  upstream pixel word valid.
REQ-008 s_data  in  DATA_W  upstream pixel word.
REQ-009 s_ready  out  1  feeder accepts a pixel word this cycle.
REQ-010 cnn_enable  out  1  run request to the CNN core.
REQ-011 cnn_img  out  IMG_SIZE*DATA_W  flattened image; pixel k occupies bits [k*DATA_W +: DATA_W].
REQ-012 cnn_value  in  OUT_W  prediction from the CNN core.
REQ-013 cnn_done  in  1  CNN core completion flag.
REQ-014 r_valid  out  1  result available downstream.
REQ-015 r_ready  in  1  downstream accepts result.
REQ-016 r_value  out  OUT_W  captured prediction.
REQ-017 r_timeout  out  1  result produced by watchdog, not by cnn_done.
REQ-018 busy  out  1  high in every state except LOAD with zero words accepted.

Function
REQ-019 FSM SHALL have states LOAD, RUN, RESULT; encoding is free.
REQ-020 In LOAD, s_ready SHALL be 1 and a word SHALL be accepted on each cycle with s_valid=1 and s_ready=1.
REQ-021 The k-th accepted word (k from 0) SHALL be written to pixel k of cnn_img; a 7-bit (clog2(IMG_SIZE)+1) counter SHALL track k.
REQ-022 On acceptance of word IMG_SIZE-1, FSM SHALL enter RUN next cycle; s_ready SHALL be 0 from that cycle; no word beyond IMG_SIZE SHALL be accepted.
REQ-023 cnn_enable SHALL be 1 exactly while in RUN, first high the cycle after the last word is accepted.
REQ-024 cnn_img SHALL be stable throughout RUN and RESULT.
REQ-025 In RUN, cnn_done=1 sampled at a clock edge SHALL load r_value<=cnn_value, set r_valid=1, clear r_timeout, enter RESULT; cnn_enable low on that same following cycle.
REQ-026 cnn_done SHALL be ignored in LOAD and RESULT.
REQ-027 In RESULT, r_valid and r_value SHALL hold until r_ready=1; on that edge r_valid<=0, counter<=0, FSM->LOAD, s_ready=1 the following cycle.
REQ-028 cnn_img SHALL NOT be cleared on return to LOAD; pixels are overwritten as new words arrive.
REQ-029 Latencies: last pixel accept -> cnn_enable 1 cycle; cnn_done -> r_valid 1 cycle; r_ready -> s_ready 1 cycle.

Reset
REQ-030 While rst=1, outputs SHALL be: s_ready 0, cnn_enable 0, cnn_img all 0, r_valid 0, r_value 0, r_timeout 0, busy 0; FSM LOAD, counter 0.
REQ-031 Reset asserted in any state, including mid-load or mid-RUN, SHALL abort immediately with no result emitted; after release, s_ready=1 at the first edge.

Configuration
REQ-032 Macro CNN_FEEDER_TIMEOUT_EN SHALL compile in a watchdog counter cleared on RUN entry and incremented each RUN cycle.
REQ-033 With the macro, reaching TIMEOUT_CYCLES in RUN without cnn_done SHALL set r_value=0, r_timeout=1, r_valid=1 and enter RESULT; cnn_done on that same edge takes priority (normal result).
REQ-034 Without the macro, no watchdog logic SHALL exist, r_timeout SHALL be tied 0, and RUN waits indefinitely.

Verification
REQ-035 Stream 64 words of value 1 back-to-back, cnn_done=1 with cnn_value=7 at 20 cycles into RUN -> cnn_img all words 1, cnn_enable high for 20 cycles, r_valid=1 with r_value=7, r_timeout=0.
REQ-036 Words k=0..63 with value k, s_valid toggled every other cycle -> exactly 64 accepts, pixel k = k, s_ready=0 during RUN despite s_valid=1.
REQ-037 Hold r_ready=0 for 10 cycles after result -> r_valid and r_value=7 stable, cnn_done pulses ignored, s_ready=0; then r_ready=1 -> s_ready=1 next cycle, second image processed correctly.
REQ-038 Assert rst after 30 words, then after 5 cycles of RUN in a second run -> all outputs at reset values, no r_valid pulse, next image loads from pixel 0.
REQ-039 With CNN_FEEDER_TIMEOUT_EN, TIMEOUT_CYCLES=16, cnn_done held 0 -> r_valid=1, r_value=0, r_timeout=1 exactly 16 cycles after RUN entry; cnn_done asserted on cycle 16 -> normal result, r_timeout=0.
